// File: rtl/t00_gpio_sequencer.sv
// Walking one-hot GPIO sequencer: each channel is driven high for BASE_DIV*prescaler cycles.
// Optional pass counter on loop_cnt is built only when T00_SEQ_LOOP_CNT_EN is defined.
module t00_gpio_sequencer #(
    parameter int NUM_CH   = 34,
    parameter int PRESC_W  = 14,
    parameter int BASE_DIV = 3000
) (
    input  logic                                       clk,
    input  logic                                       nrst,
    input  logic                                       en,
    input  logic                                       start,
    input  logic                                       stop,
    input  logic [1:0]                                 mode,
    input  logic [PRESC_W-1:0]                         prescaler,
    output logic [NUM_CH-1:0]                          gpio_out,
    output logic [NUM_CH-1:0]                          gpio_oeb,
    output logic                                       busy,
    output logic                                       done,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] step_idx,
    output logic [7:0]                                 loop_cnt
);

    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BASE_W = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
    localparam logic [IDX_W-1:0]  LAST     = IDX_W'(NUM_CH - 1);
    localparam logic [BASE_W-1:0] BASE_TOP = BASE_W'(BASE_DIV - 1);
    localparam logic [NUM_CH-1:0] ONE_HOT0 = NUM_CH'(1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t              state, state_nxt;
    logic [1:0]          mode_q;
    logic [PRESC_W-1:0]  presc_q;
    logic [BASE_W-1:0]   base_cnt;
    logic [PRESC_W-1:0]  dwell_cnt;
    logic [IDX_W-1:0]    idx, idx_adv;
    logic                dir, dir_nxt;
    logic                accept, abort, dwell_end, finish;

    assign gpio_oeb = '0;
    assign step_idx = idx;

    assign accept    = en && (state == IDLE) && start && !stop;
    assign abort     = en && (state == RUN) && stop;
    assign dwell_end = en && (state == RUN) && !stop && (base_cnt == BASE_TOP)
                       && (dwell_cnt == presc_q - PRESC_W'(1));
    assign finish    = ((mode_q == 2'b00) && (idx == LAST)) || ((mode_q == 2'b01) && (idx == '0));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (accept)                          state_nxt = RUN;
        else if (abort || (dwell_end && finish)) state_nxt = IDLE;
    end

    always_comb begin
        busy = (state == RUN);
    end

    // Next channel at the dwell terminal; dir=1 means ping-pong is walking down.
    always_comb begin
        idx_adv = idx;
        dir_nxt = dir;
        case (mode_q)
            2'b00: idx_adv = idx + IDX_W'(1);
            2'b01: idx_adv = idx - IDX_W'(1);
            2'b10: idx_adv = (idx == LAST) ? '0 : idx + IDX_W'(1);
            default: begin
                if (NUM_CH > 1) begin
                    if (!dir) begin
                        idx_adv = idx + IDX_W'(1);
                        if (idx_adv == LAST) dir_nxt = 1'b1;
                    end else begin
                        idx_adv = idx - IDX_W'(1);
                        if (idx_adv == '0) dir_nxt = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mode_q    <= 2'b00;
            presc_q   <= '0;
            base_cnt  <= '0;
            dwell_cnt <= '0;
            idx       <= '0;
            dir       <= 1'b0;
            gpio_out  <= '0;
            done      <= 1'b0;
        end else if (accept) begin
            mode_q    <= mode;
            presc_q   <= (prescaler == '0) ? PRESC_W'(1) : prescaler;
            base_cnt  <= '0;
            dwell_cnt <= '0;
            dir       <= 1'b0;
            done      <= 1'b0;
            idx       <= (mode == 2'b01) ? LAST : '0;
            gpio_out  <= (mode == 2'b01) ? (ONE_HOT0 << LAST) : ONE_HOT0;
        end else if (abort) begin
            idx      <= '0;
            gpio_out <= '0;
        end else if (en && (state == RUN)) begin
            if (base_cnt == BASE_TOP) begin
                base_cnt <= '0;
                if (dwell_end) begin
                    dwell_cnt <= '0;
                    if (finish) begin
                        idx      <= '0;
                        gpio_out <= '0;
                        done     <= 1'b1;
                    end else begin
                        idx      <= idx_adv;
                        dir      <= dir_nxt;
                        gpio_out <= ONE_HOT0 << idx_adv;
                    end
                end else begin
                    dwell_cnt <= dwell_cnt + PRESC_W'(1);
                end
            end else begin
                base_cnt <= base_cnt + BASE_W'(1);
            end
        end
    end

`ifdef T00_SEQ_LOOP_CNT_EN
    logic       wrap_evt;
    logic [7:0] loop_q;

    // A pass completes when the walk lands back on ch0 in a continuous mode.
    assign wrap_evt = ((mode_q == 2'b10) && (idx == LAST))
                   || ((mode_q == 2'b11) && dir && (idx == IDX_W'(1)));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)                                            loop_q <= 8'd0;
        else if (accept)                                      loop_q <= 8'd0;
        else if (dwell_end && wrap_evt && (loop_q != 8'hFF)) loop_q <= loop_q + 8'd1;
    end

    assign loop_cnt = loop_q;
`else
    assign loop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_t00_gpio_sequencer.sv
// Directed bench for t00_gpio_sequencer (NUM_CH=4, BASE_DIV=2): per-cycle expected
// {loop_cnt, busy, done, step_idx, gpio_out} words are queued and compared on negedge.
module tb_t00_gpio_sequencer;

    localparam int NUM_CH   = 4;
    localparam int PRESC_W  = 4;
    localparam int BASE_DIV = 2;
    localparam int W        = 16;
`ifdef T00_SEQ_LOOP_CNT_EN
    localparam int LOOP_EN = 1;
`else
    localparam int LOOP_EN = 0;
`endif

    logic               clk = 1'b0;
    logic               nrst;
    logic               en, start, stop;
    logic [1:0]         mode;
    logic [PRESC_W-1:0] prescaler;
    logic [NUM_CH-1:0]  gpio_out, gpio_oeb;
    logic               busy, done;
    logic [1:0]         step_idx;
    logic [7:0]         loop_cnt;

    logic [W-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    t00_gpio_sequencer #(.NUM_CH(NUM_CH), .PRESC_W(PRESC_W), .BASE_DIV(BASE_DIV)) dut (
        .clk(clk), .nrst(nrst), .en(en), .start(start), .stop(stop), .mode(mode),
        .prescaler(prescaler), .gpio_out(gpio_out), .gpio_oeb(gpio_oeb), .busy(busy),
        .done(done), .step_idx(step_idx), .loop_cnt(loop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] pk(input logic b, input logic d, input int ch, input int lp);
        logic [3:0] one;
        logic [3:0] g;
        one = 4'b0001;
        g   = b ? (one << ch) : 4'b0000;
        return {8'(lp * LOOP_EN), b, d, 2'(ch), g};
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_dwell(input int ch, input int n, input int lp);
        for (int i = 0; i < n; i++) exp_q.push_back(pk(1'b1, 1'b0, ch, lp));
    endtask

    task automatic push_idle(input logic d, input int lp, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(pk(1'b0, d, 0, lp));
    endtask

    task automatic run_check(input int n, input string tag);
        logic [W-1:0] e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = 1'b0;
            stop  = 1'b0;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL %s: observed queue-empty expected entry", tag);
            end else begin
                e = exp_q.pop_front();
                check(tag, {loop_cnt, busy, done, step_idx, gpio_out}, e);
            end
        end
    endtask

    initial begin
        int pp_seq[9];
        int lp;
        pp_seq = '{0, 1, 2, 3, 2, 1, 0, 1, 2};
        nrst = 1'b0; en = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00; prescaler = '0;
        #23 nrst = 1'b1;

        // reset state
        push_idle(1'b0, 0, 2);
        run_check(2, "reset");
        check("oeb", {12'd0, gpio_oeb}, 16'd0);

        // forward one-shot, P=3: 6 cycles per channel, done on cycle 25
        mode = 2'b00; prescaler = 4'd3; start = 1'b1;
        for (int c = 0; c < 4; c++) push_dwell(c, 6, 0);
        push_idle(1'b1, 0, 3);
        run_check(27, "fwd_p3");

        // reverse one-shot, P=3
        mode = 2'b01; prescaler = 4'd3; start = 1'b1;
        for (int c = 3; c >= 0; c--) push_dwell(c, 6, 0);
        push_idle(1'b1, 0, 2);
        run_check(26, "rev_p3");

        // reverse, prescaler 0 acts as 1; mid-run input changes are ignored
        mode = 2'b01; prescaler = 4'd0; start = 1'b1;
        for (int c = 3; c >= 0; c--) push_dwell(c, 2, 0);
        push_idle(1'b1, 0, 2);
        run_check(1, "rev_p0");
        mode = 2'b10; prescaler = 4'd7;
        run_check(9, "rev_p0");

        // ping-pong, P=1, then stop
        mode = 2'b11; prescaler = 4'd1; start = 1'b1;
        lp = 0;
        for (int i = 0; i < 9; i++) begin
            if (i > 0 && pp_seq[i] == 0) lp++;
            push_dwell(pp_seq[i], 2, lp);
        end
        run_check(18, "pingpong");
        stop = 1'b1;
        push_idle(1'b0, lp, 2);
        run_check(2, "pp_stop");

        // forward wrap P=2, stop mid-dwell on ch2
        mode = 2'b10; prescaler = 4'd2; start = 1'b1;
        for (int c = 0; c < 4; c++) push_dwell(c, 4, 0);
        push_dwell(0, 4, 1);
        push_dwell(1, 4, 1);
        push_dwell(2, 1, 1);
        run_check(25, "wrap");
        stop = 1'b1;
        push_idle(1'b0, 1, 2);
        run_check(2, "wrap_stop");

        // start and stop together in IDLE: stays IDLE
        start = 1'b1; stop = 1'b1;
        push_idle(1'b0, 1, 3);
        run_check(3, "start_stop");

        // forward P=1 with a 10-cycle en=0 freeze on ch1 (stop ignored while frozen)
        mode = 2'b00; prescaler = 4'd1; start = 1'b1;
        push_dwell(0, 2, 0);
        push_dwell(1, 1, 0);
        run_check(3, "freeze_pre");
        en = 1'b0; stop = 1'b1;
        push_dwell(1, 10, 0);
        run_check(10, "freeze");
        en = 1'b1;
        push_dwell(1, 1, 0);
        push_dwell(2, 2, 0);
        push_dwell(3, 2, 0);
        push_idle(1'b1, 0, 2);
        run_check(7, "freeze_post");

        // asynchronous reset mid-run
        mode = 2'b10; prescaler = 4'd2; start = 1'b1;
        push_dwell(0, 3, 0);
        run_check(3, "pre_rst");
        #2 nrst = 1'b0;
        #1;
        check("async_rst", {loop_cnt, busy, done, step_idx, gpio_out}, pk(1'b0, 1'b0, 0, 0));
        @(negedge clk);
        nrst = 1'b1;
        push_idle(1'b0, 0, 3);
        run_check(3, "post_rst");

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL queue_drain: observed %0d left expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
